// File: rtl/fp32_row_max_sub_flat_pkg.sv
// Shared FP32 constants, FSM state encoding and small helpers for the
// row-max-subtract stage that feeds the softmax exponent unit.
package fp32_row_max_sub_flat_pkg;

    localparam int unsigned FP_EXP_W = 8;
    localparam int unsigned FP_MAN_W = 23;
    localparam int          FP_BIAS  = 127;

    localparam logic [FP_EXP_W-1:0] FP_EXP_SPECIAL = '1;
    localparam logic [31:0]         FP_QNAN        = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SUB,
        DONE
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Unsigned key that orders sign-magnitude floats; -0 maps onto +0.
    function automatic logic [31:0] fp_order_key(input logic [31:0] v);
        if (v[30:0] == '0) return 32'h8000_0000;
        return v[31] ? ~v : {1'b1, v[30:0]};
    endfunction

endpackage

// File: rtl/fp32_sub_rne.sv
// Combinational binary32 subtractor y = a - b, round-to-nearest-even,
// subnormal inputs read as zero and underflowing results flushed to signed zero.
module fp32_sub_rne
    import fp32_row_max_sub_flat_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    logic              sx, sy, sticky, rup, carry;
    logic [7:0]        ea, eb, ex, ey, d;
    logic [23:0]       ma, mb, mx, my, frc;
    logic [26:0]       ys, mask, n, nn;
    logic [27:0]       sum;
    logic [4:0]        lz;
    logic signed [9:0] en, ef;

    always_comb begin
        sx = 1'b0; sy = 1'b0; sticky = 1'b0; rup = 1'b0; carry = 1'b0;
        ex = '0; ey = '0; d = '0; mx = '0; my = '0; frc = '0;
        ys = '0; mask = '0; n = '0; nn = '0; sum = '0; lz = '0; en = '0; ef = '0;
        y = '0;

        ea = a[FP_MAN_W +: FP_EXP_W];
        eb = b[FP_MAN_W +: FP_EXP_W];
        ma = (ea == '0) ? '0 : {1'b1, a[FP_MAN_W-1:0]};
        mb = (eb == '0) ? '0 : {1'b1, b[FP_MAN_W-1:0]};

        // a - b is done as a + (-b); x is the larger-magnitude operand
        if ({ea, ma} >= {eb, mb}) begin
            sx = a[31];  ex = ea; mx = ma;
            sy = ~b[31]; ey = eb; my = mb;
        end else begin
            sx = ~b[31]; ex = eb; mx = mb;
            sy = a[31];  ey = ea; my = ma;
        end

        d = ex - ey;
        if (d >= 8'd27) begin
            ys     = '0;
            sticky = |my;
        end else begin
            mask   = ~(27'h7FF_FFFF << d);
            ys     = {my, 3'b000} >> d;
            sticky = |({my, 3'b000} & mask);
        end
        ys[0] = ys[0] | sticky;

        if (sx == sy) sum = {1'b0, mx, 3'b000} + {1'b0, ys};
        else          sum = {1'b0, mx, 3'b000} - {1'b0, ys};

        en = $signed({2'b00, ex});
        if (sum[27]) begin
            n  = {sum[27:2], sum[1] | sum[0]};
            en = en + 10'sd1;
        end else begin
            n = sum[26:0];
        end

        for (int unsigned i = 0; i < 27; i++) begin
            if (n[i]) lz = 5'(26 - i);
        end
        nn = n << lz;
        en = en - $signed({5'b00000, lz});

        rup   = nn[2] & (nn[1] | nn[0] | nn[3]);
        frc   = {1'b0, nn[25:3]} + 24'(rup);
        carry = frc[23];
        ef    = en + $signed({9'b0, carry});

        if (ea == FP_EXP_SPECIAL || eb == FP_EXP_SPECIAL) y = FP_QNAN;
        else if (!nn[26])                                  y = '0;
        else if (ef <= 10'sd0)                             y = {sx, 31'b0};
        else if (ef > 2 * FP_BIAS)                         y = {sx, FP_EXP_SPECIAL, 23'b0};
        else                                               y = {sx, ef[7:0], frc[22:0]};
    end

endmodule

// File: rtl/fp32_row_max_sub_flat.sv
// Per-row max search followed by x - rowmax for every element, so that the
// downstream exponent stage only ever sees non-positive inputs.
module fp32_row_max_sub_flat
    import fp32_row_max_sub_flat_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    input  logic [DATA_W*ROWS*COLS-1:0]     in_flat,
    output logic [DATA_W*ROWS*COLS-1:0]     out_flat,
    output logic [idx_w(ROWS)-1:0]          cur_r,
    output logic [idx_w(COLS)-1:0]          cur_c,
    output logic [idx_w(ROWS*COLS)-1:0]     cur_idx
);

    localparam int          RW = idx_w(ROWS);
    localparam int          CW = idx_w(COLS);
    localparam int          IW = idx_w(ROWS * COLS);
    localparam int unsigned NE = ROWS * COLS;
    localparam logic [RW-1:0] LAST_R = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_C = CW'(COLS - 1);

    state_t        state, state_n;
    logic [RW-1:0] r;
    logic [CW-1:0] c;
    logic [IW-1:0] idx;
    logic [31:0]   run_max, elem, diff;
    logic          nan_row;
    logic [31:0]   out_mem [NE];

    always_comb begin
        idx  = IW'(int'(r) * COLS + int'(c));
        elem = in_flat[DATA_W*int'(idx) +: DATA_W];
    end

    fp32_sub_rne u_sub (
        .a (elem),
        .b (run_max),
        .y (diff)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        cur_r   = r;
        cur_c   = c;
        cur_idx = idx;
        unique case (state)
            IDLE: if (start) state_n = SCAN;
            SCAN: begin
                busy = 1'b1;
                if (c == LAST_C) state_n = SUB;
            end
            SUB: begin
                busy = 1'b1;
                if (c == LAST_C) state_n = (r == LAST_R) ? DONE : SCAN;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r       <= '0;
            c       <= '0;
            run_max <= '0;
            nan_row <= 1'b0;
            for (int unsigned i = 0; i < NE; i++) out_mem[i] <= '0;
        end else begin
            unique case (state)
                SCAN: begin
                    if (c == '0 || fp_order_key(elem) > fp_order_key(run_max)) run_max <= elem;
                    nan_row <= (c != '0 && nan_row) || (elem[30:23] == FP_EXP_SPECIAL);
                    c       <= (c == LAST_C) ? '0 : c + 1'b1;
                end
                SUB: begin
                    out_mem[idx] <= nan_row ? FP_QNAN : diff;
                    if (c == LAST_C) begin
                        c <= '0;
                        r <= (r == LAST_R) ? '0 : r + 1'b1;
                    end else begin
                        c <= c + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NE; g++) begin : g_out
        assign out_flat[DATA_W*g +: DATA_W] = out_mem[g];
    end

endmodule

// File: tb/tb_fp32_row_max_sub_flat.sv
// Self-checking bench for fp32_row_max_sub_flat: table vectors, timing and reset
// sequences, and random matrices checked against an exact-integer reference.
module tb_fp32_row_max_sub_flat;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    typedef logic signed [299:0] fx_t;
    typedef struct packed {
        logic [3:0][31:0] in;
        logic [3:0][31:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst, start, busy, done;
    logic [511:0] in_flat, out_flat;
    logic [1:0]   cur_r, cur_c;
    logic [3:0]   cur_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp32_row_max_sub_flat #(.ROWS(ROWS), .COLS(COLS), .DATA_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .in_flat  (in_flat),
        .out_flat (out_flat),
        .cur_r    (cur_r),
        .cur_c    (cur_c),
        .cur_idx  (cur_idx)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Exact value scaled by 2^149 (smallest normal step); subnormals read as zero.
    function automatic fx_t to_fx(input logic [31:0] v);
        fx_t m;
        int  e;
        e = int'(v[30:23]);
        if (e == 0) return '0;
        m = '0;
        m[23:0] = {1'b1, v[22:0]};
        m = m << (e - 1);
        return v[31] ? -m : m;
    endfunction

    function automatic logic [31:0] from_fx(input fx_t d);
        fx_t mag, q, rem, half;
        int  p, sh, e;
        bit  neg;
        if (d == 0) return 32'h0;
        neg = (d < 0);
        mag = neg ? -d : d;
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        if (p < 23) return {neg, 31'b0};
        sh  = p - 23;
        q   = mag >> sh;
        rem = mag - (q << sh);
        if (sh > 0) begin
            half = '0;
            half[sh-1] = 1'b1;
            if (rem > half || (rem == half && q[0])) q = q + 1;
        end
        if (q[24]) begin
            q = q >> 1;
            p++;
        end
        e = p - 22;
        if (e <= 0)   return {neg, 31'b0};
        if (e >= 255) return {neg, 8'hFF, 23'b0};
        return {neg, 8'(e), q[22:0]};
    endfunction

    function automatic logic [511:0] model(input logic [511:0] m);
        logic [511:0] o;
        logic [31:0]  x, best;
        bit           nan;
        o = '0;
        for (int r = 0; r < ROWS; r++) begin
            nan  = 0;
            best = m[32*(r*COLS) +: 32];
            for (int c = 0; c < COLS; c++) begin
                x = m[32*(r*COLS+c) +: 32];
                if (x[30:23] == 8'hFF) nan = 1;
                if (to_fx(x) > to_fx(best)) best = x;
            end
            for (int c = 0; c < COLS; c++) begin
                x = m[32*(r*COLS+c) +: 32];
                o[32*(r*COLS+c) +: 32] = nan ? 32'h7FC0_0000 : from_fx(to_fx(x) - to_fx(best));
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] rand_fp();
        int unsigned sel;
        logic [7:0]  e;
        sel = $urandom_range(0, 31);
        if (sel == 0)      e = 8'h00;
        else if (sel == 1) e = 8'hFF;
        else if (sel <= 3) e = 8'($urandom_range(1, 254));
        else if (sel == 4) e = 8'($urandom_range(1, 3));
        else if (sel == 5) e = 8'($urandom_range(252, 254));
        else               e = 8'($urandom_range(120, 135));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    function automatic logic [511:0] rand_matrix();
        logic [511:0] m;
        m = '0;
        for (int i = 0; i < ROWS*COLS; i++) begin
            if (i % COLS != 0 && $urandom_range(0, 5) == 0) m[32*i +: 32] = m[32*(i-1) +: 32];
            else                                              m[32*i +: 32] = rand_fp();
        end
        return m;
    endfunction

    task automatic check_out(input logic [511:0] e, input string tag);
        for (int i = 0; i < ROWS*COLS; i++)
            chk($sformatf("%s[%0d]", tag, i), out_flat[32*i +: 32], e[32*i +: 32]);
    endtask

    // Element index expected in the k-th sample after the start edge.
    function automatic logic [31:0] exp_idx(input int k);
        return 32'((k / (2*COLS)) * COLS + (k % (2*COLS)) % COLS);
    endfunction

    task automatic run_matrix(input logic [511:0] m, input bit mid_start);
        int n, bc;
        in_flat = m;
        start   = 1'b1;
        tick();
        start = 1'b0;
        n  = 0;
        bc = busy ? 1 : 0;
        chk("cur_idx", 32'(cur_idx), exp_idx(0));
        while (!done && n < 100) begin
            start = mid_start && (n == 10);
            tick();
            start = 1'b0;
            n++;
            if (busy) bc++;
            if (!done && n < 2*ROWS*COLS) begin
                chk("cur_idx", 32'(cur_idx), exp_idx(n));
                chk("cur_rc", 32'({cur_r, cur_c}), exp_idx(n));
            end
        end
        chk("done_latency", n, 2*ROWS*COLS);
        chk("busy_cycles", bc, 2*ROWS*COLS);
        tick();
        chk("done_width", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_cur_idx", 32'(cur_idx), 0);
    endtask

    vec_t         tbl [8];
    logic [511:0] m, ma, mb, ea, eb;

    initial begin
        tbl[0] = '{in: {32'hBF800000, 32'h40000000, 32'h40400000, 32'h3F800000},
                   exp: {32'hC0800000, 32'hBF800000, 32'h00000000, 32'hC0000000}};
        tbl[1] = '{in: {32'h00000000, 32'h80000000, 32'hC0000000, 32'hBF800000},
                   exp: {32'h00000000, 32'h00000000, 32'hC0000000, 32'hBF800000}};
        tbl[2] = '{in: {32'h3F800000, 32'h3F800000, 32'h4C000000, 32'h3F800000},
                   exp: {32'hCC000000, 32'hCC000000, 32'h00000000, 32'hCC000000}};
        tbl[3] = '{in: {32'h4B800000, 32'h3F800000, 32'h4B800000, 32'h3F800000},
                   exp: {32'h00000000, 32'hCB7FFFFF, 32'h00000000, 32'hCB7FFFFF}};
        tbl[4] = '{in: {32'h40400000, 32'h40000000, 32'h7F800000, 32'h3F800000},
                   exp: {32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000}};
        tbl[5] = '{in: {32'hBF800000, 32'h00000000, 32'h80000001, 32'h00400000},
                   exp: {32'hBF800000, 32'h00000000, 32'h00000000, 32'h00000000}};
        tbl[6] = '{in: {32'h00A00000, 32'h00C00000, 32'h00C00000, 32'h00800000},
                   exp: {32'h80000000, 32'h00000000, 32'h00000000, 32'h80000000}};
        tbl[7] = '{in: {32'h00000000, 32'h3F800000, 32'h7F7FFFFF, 32'hFF7FFFFF},
                   exp: {32'hFF7FFFFF, 32'hFF7FFFFF, 32'h00000000, 32'hFF800000}};
        for (int r = 0; r < 4; r++) begin
            ma[128*r +: 128] = tbl[r].in;
            ea[128*r +: 128] = tbl[r].exp;
            mb[128*r +: 128] = tbl[r+4].in;
            eb[128*r +: 128] = tbl[r+4].exp;
        end

        rst = 1'b1; start = 1'b0; in_flat = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cur_idx", 32'(cur_idx), 0);
        check_out('0, "rst_out");

        rst = 1'b1; start = 1'b1; in_flat = ma;
        tick();
        rst = 1'b0; start = 1'b0;
        tick();
        chk("start_with_rst_busy", 32'(busy), 0);
        tick();
        chk("start_with_rst_done", 32'(done), 0);

        run_matrix(ma, 1'b1);
        check_out(ea, "tblA");
        run_matrix(mb, 1'b0);
        check_out(eb, "tblB");
        repeat (3) tick();
        check_out(eb, "hold");

        m = rand_matrix();
        in_flat = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (21) tick();
        chk("pre_rst_cur_r", 32'(cur_r), 2);
        chk("pre_rst_cur_c", 32'(cur_c), 1);
        chk("pre_rst_busy", 32'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_cur_idx", 32'(cur_idx), 0);
        check_out('0, "mid_rst_out");
        repeat (3) begin
            tick();
            chk("mid_rst_idle", 32'({busy, done}), 0);
        end
        m = rand_matrix();
        run_matrix(m, 1'b0);
        check_out(model(m), "post_rst");

        for (int t = 0; t < 25; t++) begin
            m = rand_matrix();
            run_matrix(m, t[0]);
            check_out(model(m), $sformatf("rand%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
